uart_tx_perip: RTL and testbench
================================

// Module: uart_tx_perip
// PURPOSE
//   UART transmit engine fed from the peripheral side of a perip_mem instance.
//   Software writes a divisor, a data byte and a start bit over the bus. This block polls
//   the control window through the perip read port, serialises the byte onto tx_o (8N1),
//   and posts status back through the perip write port.
//   Register window (byte offsets from BASE): +0..+1 DIV (cycles/bit, LE), +2 TXDATA,
//   +3 CTRL (bit0 START), +4 STAT (bit0 BUSY, bit1 DONE).
//   STAT must be bus read-only in the perip_mem ALLOW_WRITE mask.
// PARAMETERS
//   BASE   32'h0  byte address of the register window inside perip_mem
//   DIV_W  16     divisor width; DIV==0 is treated as 1
// PORTS
//   clk_i          in   1   clock; all state updates on posedge
//   rst_i          in   1   asynchronous, active-high reset
//   write_perip    out  1   perip write strobe to perip_mem
//   be_perip       out  4   byte enables for the perip read/write (shared by both)
//   wraddr_perip   out  32  perip write byte address
//   data_i_perip   out  32  perip write data; byte placed in [7:0]
//   rdaddr_perip   out  32  perip read byte address
//   data_o_perip   in   32  perip read data (combinational from perip_mem)
//   tx_o           out  1   serial output; idles high
// BEHAVIOUR
//   Reset: state=INIT, tx_o=1, write_perip=0, be_perip=0, wraddr=rdaddr=BASE, data_i=0.
//     Counters and latches clear. Async assert; outputs take reset values immediately.
//   All outputs are registered or decoded from state only; none depend combinationally on data_o_perip.
//   FSM (one transition per clk_i edge):
//     INIT : write STAT=0x00 (wraddr=BASE+4, be=0001) -> IDLE.
//     IDLE : rdaddr=BASE, be=1111, write_perip=0.
//            If data_o_perip[24] is set: latch DIV=data_o[15:0] (0->1) and DATA=data_o[23:16]
//            -> CLR. Otherwise stay.
//     CLR  : write CTRL=0x00 (wraddr=BASE+3, be=0001) -> SETB.
//     SETB : write STAT=0x01 (BUSY, DONE cleared) -> START. tx_o<=0 on this edge.
//     START: hold tx_o=0 for DIV cycles -> DATA. tx_o<=DATA[0].
//     DATA : each bit held DIV cycles, LSB first; after bit 7 -> STOP with tx_o<=1.
//     STOP : hold tx_o=1 for DIV cycles -> FIN.
//     FIN  : write STAT=0x02 (DONE, BUSY clear) -> IDLE.
//   Latency: START seen in IDLE at edge T -> tx_o falls at edge T+2.
//     Frame length is 10*DIV cycles. DONE commits 1 cycle after the stop bit ends.
//   Bit timing: down-counter loads DIV-1 at each bit boundary; the bit advances when the counter hits 0.
//   DIV and DATA are frozen at latch time. Bus writes to +0..+2 mid-frame affect only the next frame.
//   START re-written during a frame is left set and triggers a new frame on return to IDLE.
//     The DONE->BUSY sequence repeats.
//   Same-cycle collision: perip_mem gives the bus priority. If the bus writes CTRL during CLR,
//     START stays set and a second frame follows. This is intended; no retry logic.
//   Reset mid-frame: tx_o returns high at once. INIT rewrites STAT=0 (perip_mem has no reset).
//   Only one perip write per cycle; be_perip=0001 during every write cycle.
// TESTING
//   T1 DIV=4, TXDATA=0xA5, CTRL=1 -> CTRL reads 0, then STAT=0x01.
//      tx_o: 0, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 1. STAT=0x02 after 40+ cycles.
//   T2 DIV=0, TXDATA=0xFF -> 1 cycle/bit frame: low for 1 cycle, then high for 9 cycles; STAT=0x02.
//   T3 Mid-frame, bus writes TXDATA=0x00 and CTRL=1 -> first frame unchanged.
//      A second 0x00 frame follows immediately after FIN.
//   T4 Bus writes CTRL=1 in the same cycle as CLR -> CTRL remains 1; exactly two frames are sent.
//   T5 Assert rst_i during DATA bit 3 -> tx_o=1 asynchronously.
//      After release, STAT=0x00 and no frame until CTRL=1 is written again.
//   T6 BASE=4 in a SIZE=10 perip_mem -> the same sequence as T1 at offsets 4..8; bytes 0..3 untouched.

Source files
------------

// File: rtl/uart_tx_perip.sv
// UART 8N1 transmitter that polls a perip_mem control window for START,
// shifts the latched byte out on tx_o and reports BUSY/DONE back into the window.
module uart_tx_perip #(
    parameter logic [31:0] BASE  = 32'h0,
    parameter int          DIV_W = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        write_perip,
    output logic [3:0]  be_perip,
    output logic [31:0] wraddr_perip,
    output logic [31:0] data_i_perip,
    output logic [31:0] rdaddr_perip,
    input  logic [31:0] data_o_perip,
    output logic        tx_o
);
    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_CLR, S_SETB, S_START, S_DATA, S_STOP, S_FIN
    } state_t;

    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [31:0]      ADDR_CTRL = BASE + 32'd3;
    localparam logic [31:0]      ADDR_STAT = BASE + 32'd4;

    state_t           state_q;
    logic             init_q;
    logic             tx_q;
    logic             wr_q;
    logic [3:0]       be_q;
    logic [31:0]      wraddr_q;
    logic [7:0]       wdata_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] div_d;
    logic [7:0]       shift_q;
    logic [2:0]       bit_q;
    logic             unused_rd;

    // A programmed divisor of zero behaves as one cycle per bit.
    assign div_d = (DIV_W'(data_o_perip[15:0]) == '0) ? DIV_ONE : DIV_W'(data_o_perip[15:0]);
    assign unused_rd = ^data_o_perip[31:25];

    assign write_perip  = wr_q;
    assign be_perip     = be_q;
    assign wraddr_perip = wraddr_q;
    assign data_i_perip = {24'h0, wdata_q};
    assign rdaddr_perip = BASE;
    assign tx_o         = tx_q;

    // Bus outputs are registered on entry to the state that owns them,
    // so each write is presented for exactly the cycle spent in that state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_INIT;
            init_q   <= 1'b0;
            tx_q     <= 1'b1;
            wr_q     <= 1'b0;
            be_q     <= 4'h0;
            wraddr_q <= BASE;
            wdata_q  <= 8'h00;
            div_q    <= '0;
            cnt_q    <= '0;
            shift_q  <= 8'h00;
            bit_q    <= 3'd0;
        end else begin
            wr_q <= 1'b0;
            be_q <= 4'h0;
            case (state_q)
                S_INIT: begin
                    if (!init_q) begin
                        init_q   <= 1'b1;
                        wr_q     <= 1'b1;
                        be_q     <= 4'b0001;
                        wraddr_q <= ADDR_STAT;
                        wdata_q  <= 8'h00;
                    end else begin
                        state_q <= S_IDLE;
                        be_q    <= 4'hF;
                    end
                end
                S_IDLE: begin
                    if (data_o_perip[24]) begin
                        div_q    <= div_d;
                        shift_q  <= data_o_perip[23:16];
                        state_q  <= S_CLR;
                        wr_q     <= 1'b1;
                        be_q     <= 4'b0001;
                        wraddr_q <= ADDR_CTRL;
                        wdata_q  <= 8'h00;
                    end else begin
                        be_q <= 4'hF;
                    end
                end
                S_CLR: begin
                    state_q  <= S_SETB;
                    wr_q     <= 1'b1;
                    be_q     <= 4'b0001;
                    wraddr_q <= ADDR_STAT;
                    wdata_q  <= 8'h01;
                end
                S_SETB: begin
                    state_q <= S_START;
                    tx_q    <= 1'b0;
                    cnt_q   <= div_q - DIV_ONE;
                end
                S_START: begin
                    if (cnt_q == '0) begin
                        state_q <= S_DATA;
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                        bit_q   <= 3'd0;
                        cnt_q   <= div_q - DIV_ONE;
                    end else begin
                        cnt_q <= cnt_q - DIV_ONE;
                    end
                end
                S_DATA: begin
                    if (cnt_q == '0) begin
                        cnt_q <= div_q - DIV_ONE;
                        if (bit_q == 3'd7) begin
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                            bit_q   <= bit_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - DIV_ONE;
                    end
                end
                S_STOP: begin
                    if (cnt_q == '0) begin
                        state_q  <= S_FIN;
                        wr_q     <= 1'b1;
                        be_q     <= 4'b0001;
                        wraddr_q <= ADDR_STAT;
                        wdata_q  <= 8'h02;
                    end else begin
                        cnt_q <= cnt_q - DIV_ONE;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    be_q    <= 4'hF;
                end
                default: state_q <= S_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_perip.sv
// Bench for uart_tx_perip: two instances (BASE=0 and BASE=4), each backed by a
// small byte-addressed perip_mem model where bus writes win over perip writes.
module tb_uart_tx_perip;
    localparam int MEM_SZ = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    logic        wr0, wr1, tx0, tx1;
    logic [3:0]  be0, be1;
    logic [31:0] wa0, wa1, wd0, wd1, ra0, ra1, rd0, rd1;

    logic [7:0] mem0 [0:MEM_SZ-1] = '{default: 8'hEE};
    logic [7:0] mem1 [0:MEM_SZ-1] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hEE,
                                      8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE};
    logic       bus_we [2] = '{1'b0, 1'b0};
    int         bus_a  [2] = '{0, 0};
    logic [7:0] bus_d  [2] = '{8'h00, 8'h00};

    uart_tx_perip #(.BASE(32'h0), .DIV_W(16)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .write_perip(wr0), .be_perip(be0),
        .wraddr_perip(wa0), .data_i_perip(wd0), .rdaddr_perip(ra0),
        .data_o_perip(rd0), .tx_o(tx0));

    uart_tx_perip #(.BASE(32'h4), .DIV_W(16)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .write_perip(wr1), .be_perip(be1),
        .wraddr_perip(wa1), .data_i_perip(wd1), .rdaddr_perip(ra1),
        .data_o_perip(rd1), .tx_o(tx1));

    // perip write first, bus write last so the bus wins a same-byte collision; STAT is bus read-only
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (wr0 && be0[k] && (int'(wa0) + k) < MEM_SZ) mem0[int'(wa0) + k] <= wd0[8*k +: 8];
            if (wr1 && be1[k] && (int'(wa1) + k) < MEM_SZ) mem1[int'(wa1) + k] <= wd1[8*k +: 8];
        end
        if (bus_we[0] && bus_a[0] != 4 && bus_a[0] < MEM_SZ) mem0[bus_a[0]] <= bus_d[0];
        if (bus_we[1] && bus_a[1] != 8 && bus_a[1] < MEM_SZ) mem1[bus_a[1]] <= bus_d[1];
    end

    always_comb begin
        rd0 = '0;
        rd1 = '0;
        for (int k = 0; k < 4; k++) begin
            if ((int'(ra0) + k) < MEM_SZ) rd0[8*k +: 8] = mem0[int'(ra0) + k];
            if ((int'(ra1) + k) < MEM_SZ) rd1[8*k +: 8] = mem1[int'(ra1) + k];
        end
    end

    function automatic logic get_tx(input int inst);
        return (inst == 0) ? tx0 : tx1;
    endfunction

    // Caller is at a negedge; the byte commits on the next posedge.
    task automatic bus_wr(input int inst, input int a, input logic [7:0] d);
        bus_we[inst] = 1'b1;
        bus_a[inst]  = a;
        bus_d[inst]  = d;
        @(negedge clk);
        bus_we[inst] = 1'b0;
    endtask

    task automatic set_regs(input int inst, input logic [15:0] div, input logic [7:0] data);
        int base;
        base = (inst == 0) ? 0 : 4;
        bus_wr(inst, base,     div[7:0]);
        bus_wr(inst, base + 1, div[15:8]);
        bus_wr(inst, base + 2, data);
    endtask

    task automatic wait_fall(input int inst, input int max, output int cyc);
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (get_tx(inst) === 1'b0) break;
            if (cyc >= max) begin
                cyc = -1;
                break;
            end
        end
    endtask

    // Entered on the first low sample; walks all 10*div cycles of the frame.
    task automatic check_frame(input int inst, input int div, input logic [7:0] data, input string name);
        int   bad_i;
        logic exp, bad_got, bad_exp;
        bad_i = -1;
        bad_got = 1'b0;
        bad_exp = 1'b0;
        for (int i = 0; i < 10 * div; i++) begin
            if (i > 0) @(negedge clk);
            if (i < div)            exp = 1'b0;
            else if (i >= 9 * div)  exp = 1'b1;
            else                    exp = data[i / div - 1];
            if (get_tx(inst) !== exp && bad_i < 0) begin
                bad_i   = i;
                bad_got = get_tx(inst);
                bad_exp = exp;
            end
        end
        n_run++;
        if (bad_i >= 0) begin
            n_fail++;
            $display("FAIL %s: cycle %0d tx=%b expected %b", name, bad_i, bad_got, bad_exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_run++;
        if (tx0 !== 1'b1 || tx1 !== 1'b1) begin
            n_fail++; $display("FAIL reset_tx: tx0=%b tx1=%b expected 1", tx0, tx1);
        end
        n_run++;
        if ({wr0, be0, wr1, be1} !== 10'b0) begin
            n_fail++; $display("FAIL reset_wr_be: wr0=%b be0=%h wr1=%b be1=%h expected 0", wr0, be0, wr1, be1);
        end
        n_run++;
        if (wa0 !== 32'h0 || ra0 !== 32'h0 || wa1 !== 32'h4 || ra1 !== 32'h4) begin
            n_fail++; $display("FAIL reset_addr: wa0=%h ra0=%h wa1=%h ra1=%h expected 0,0,4,4", wa0, ra0, wa1, ra1);
        end
        n_run++;
        if (wd0 !== 32'h0 || wd1 !== 32'h0) begin
            n_fail++; $display("FAIL reset_wdata: wd0=%h wd1=%h expected 0", wd0, wd1);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_run++;
        if (mem0[4] !== 8'h00 || mem1[8] !== 8'h00) begin
            n_fail++; $display("FAIL init_stat: stat0=%h stat1=%h expected 00", mem0[4], mem1[8]);
        end
        n_run++;
        if (be0 !== 4'hF || wr0 !== 1'b0 || tx0 !== 1'b1) begin
            n_fail++; $display("FAIL idle_read: be0=%h wr0=%b tx0=%b expected f,0,1", be0, wr0, tx0);
        end
    endtask

    task automatic test_single_frame();
        int cyc;
        set_regs(0, 16'd4, 8'hA5);
        bus_wr(0, 3, 8'h01);
        wait_fall(0, 20, cyc);
        n_run++;
        if (cyc !== 3) begin n_fail++; $display("FAIL t1_latency: %0d cycles expected 3", cyc); end
        n_run++;
        if (mem0[3] !== 8'h00) begin n_fail++; $display("FAIL t1_ctrl_clr: ctrl=%h expected 00", mem0[3]); end
        n_run++;
        if (mem0[4] !== 8'h01) begin n_fail++; $display("FAIL t1_stat_busy: stat=%h expected 01", mem0[4]); end
        check_frame(0, 4, 8'hA5, "t1_frame");
        repeat (2) @(negedge clk);
        n_run++;
        if (mem0[4] !== 8'h02) begin n_fail++; $display("FAIL t1_stat_done: stat=%h expected 02", mem0[4]); end
    endtask

    task automatic test_div_zero();
        int cyc;
        set_regs(0, 16'd0, 8'hFF);
        bus_wr(0, 3, 8'h01);
        wait_fall(0, 20, cyc);
        n_run++;
        if (cyc !== 3) begin n_fail++; $display("FAIL t2_latency: %0d cycles expected 3", cyc); end
        check_frame(0, 1, 8'hFF, "t2_frame");
        repeat (2) @(negedge clk);
        n_run++;
        if (mem0[4] !== 8'h02) begin n_fail++; $display("FAIL t2_stat_done: stat=%h expected 02", mem0[4]); end
    endtask

    task automatic test_midframe_rewrite();
        int cyc;
        set_regs(0, 16'd4, 8'h3C);
        bus_wr(0, 3, 8'h01);
        wait_fall(0, 20, cyc);
        fork
            check_frame(0, 4, 8'h3C, "t3_frame1");
            begin
                repeat (8) @(negedge clk);
                bus_wr(0, 2, 8'h00);
                bus_wr(0, 3, 8'h01);
            end
        join
        wait_fall(0, 20, cyc);
        n_run++;
        if (cyc !== 5) begin n_fail++; $display("FAIL t3_gap: %0d cycles expected 5", cyc); end
        check_frame(0, 4, 8'h00, "t3_frame2");
        repeat (2) @(negedge clk);
        n_run++;
        if (mem0[4] !== 8'h02 || mem0[3] !== 8'h00) begin
            n_fail++; $display("FAIL t3_end: stat=%h ctrl=%h expected 02,00", mem0[4], mem0[3]);
        end
    endtask

    task automatic test_ctrl_collision();
        int cyc;
        set_regs(0, 16'd2, 8'h5A);
        bus_wr(0, 3, 8'h01);
        @(negedge clk);
        bus_wr(0, 3, 8'h01);
        n_run++;
        if (mem0[3] !== 8'h01) begin n_fail++; $display("FAIL t4_ctrl_kept: ctrl=%h expected 01", mem0[3]); end
        wait_fall(0, 20, cyc);
        n_run++;
        if (cyc !== 1) begin n_fail++; $display("FAIL t4_latency: %0d cycles expected 1", cyc); end
        check_frame(0, 2, 8'h5A, "t4_frame1");
        wait_fall(0, 20, cyc);
        n_run++;
        if (cyc !== 5) begin n_fail++; $display("FAIL t4_gap: %0d cycles expected 5", cyc); end
        check_frame(0, 2, 8'h5A, "t4_frame2");
        wait_fall(0, 40, cyc);
        n_run++;
        if (cyc !== -1) begin n_fail++; $display("FAIL t4_no_third: tx fell after %0d cycles expected none", cyc); end
        n_run++;
        if (mem0[4] !== 8'h02 || mem0[3] !== 8'h00) begin
            n_fail++; $display("FAIL t4_end: stat=%h ctrl=%h expected 02,00", mem0[4], mem0[3]);
        end
    endtask

    task automatic test_reset_midframe();
        int cyc;
        set_regs(0, 16'd4, 8'h96);
        bus_wr(0, 3, 8'h01);
        wait_fall(0, 20, cyc);
        repeat (17) @(negedge clk);
        n_run++;
        if (tx0 !== 1'b0) begin n_fail++; $display("FAIL t5_bit3: tx=%b expected 0", tx0); end
        rst = 1'b1;
        #1;
        n_run++;
        if (tx0 !== 1'b1 || wr0 !== 1'b0 || be0 !== 4'h0) begin
            n_fail++; $display("FAIL t5_async: tx=%b wr=%b be=%h expected 1,0,0", tx0, wr0, be0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_run++;
        if (mem0[4] !== 8'h00) begin n_fail++; $display("FAIL t5_stat_clr: stat=%h expected 00", mem0[4]); end
        wait_fall(0, 30, cyc);
        n_run++;
        if (cyc !== -1) begin n_fail++; $display("FAIL t5_quiet: tx fell after %0d cycles expected none", cyc); end
        bus_wr(0, 3, 8'h01);
        wait_fall(0, 20, cyc);
        n_run++;
        if (cyc !== 3) begin n_fail++; $display("FAIL t5_restart: %0d cycles expected 3", cyc); end
        check_frame(0, 4, 8'h96, "t5_frame");
        repeat (2) @(negedge clk);
        n_run++;
        if (mem0[4] !== 8'h02) begin n_fail++; $display("FAIL t5_stat_done: stat=%h expected 02", mem0[4]); end
    endtask

    task automatic test_base_offset();
        int cyc;
        set_regs(1, 16'd4, 8'hA5);
        bus_wr(1, 7, 8'h01);
        wait_fall(1, 20, cyc);
        n_run++;
        if (cyc !== 3) begin n_fail++; $display("FAIL t6_latency: %0d cycles expected 3", cyc); end
        n_run++;
        if (mem1[7] !== 8'h00 || mem1[8] !== 8'h01) begin
            n_fail++; $display("FAIL t6_clr_busy: ctrl=%h stat=%h expected 00,01", mem1[7], mem1[8]);
        end
        check_frame(1, 4, 8'hA5, "t6_frame");
        repeat (2) @(negedge clk);
        n_run++;
        if (mem1[8] !== 8'h02) begin n_fail++; $display("FAIL t6_stat_done: stat=%h expected 02", mem1[8]); end
        n_run++;
        if ({mem1[0], mem1[1], mem1[2], mem1[3]} !== 32'h11223344) begin
            n_fail++; $display("FAIL t6_low_bytes: %h %h %h %h expected 11 22 33 44", mem1[0], mem1[1], mem1[2], mem1[3]);
        end
        n_run++;
        if (tx0 !== 1'b1 || mem0[4] !== 8'h02) begin
            n_fail++; $display("FAIL t6_other_idle: tx0=%b stat0=%h expected 1,02", tx0, mem0[4]);
        end
    endtask

    initial begin
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_div_zero();
        test_midframe_rewrite();
        test_ctrl_collision();
        test_reset_midframe();
        test_base_offset();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
